// File: rtl/sisc_mc_core_if.sv
// +----------------------------------------------------------------------+
// | sisc_mc_core_if : instruction-fetch handshake between core and imem   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface sisc_mc_core_if #(
  parameter int PC_W = 16
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            rdy;
  logic [31:0]     data;

  modport master (output req, addr, input rdy, data);
  modport slave  (input req, addr, output rdy, data);
endinterface

`default_nettype wire

// File: rtl/sisc_mc_core.sv
// +----------------------------------------------------------------------+
// | sisc_mc_core : parametrised multicycle SISC core with fetch handshake |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sisc_mc_core #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  sisc_mc_core_if.master    imem,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        stat,
  output logic              halted,
  output logic              illegal,
  output logic              retire,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_alur = 4'h1;
  localparam logic [3:0] c_op_alui = 4'h2;
  localparam logic [3:0] c_op_brc  = 4'h4;
  localparam logic [3:0] c_op_jmp  = 4'h5;
  localparam logic [3:0] c_op_halt = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_ir;
  logic [PC_W-1:0]     r_pc, r_target;
  logic [3:0]          r_stat, r_flags;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_a, r_b, r_imm, r_res;
  logic [DATA_W-1:0]   r_regs [16];

  logic [3:0]          w_op, w_mm, w_rs, w_rt, w_rd, w_widx;
  logic                w_wen;
  logic [DATA_W-1:0]   w_opb, w_res;
  logic [DATA_W:0]     w_sum, w_dif;
  logic                w_c, w_v;

  assign w_op = r_ir[31:28];
  assign w_mm = r_ir[27:24];
  assign w_rs = r_ir[23:20];
  assign w_rt = r_ir[19:16];
  assign w_rd = r_ir[15:12];

  // Indices beyond the implemented file, and R0, always read as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
    if (idx == 4'd0 || int'(idx) >= NREGS) return '0;
    return r_regs[idx];
  endfunction

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (imem.rdy) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = (w_op == c_op_halt) ? S_HALT : S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_opb = (w_op == c_op_alui) ? r_imm : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_opb};
    w_dif = {1'b0, r_a} - {1'b0, w_opb};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_mm[2:0])
      3'd0: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (r_a[MSB] == w_opb[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      3'd1: begin
        w_res = w_dif[MSB:0];
        w_c   = ~w_dif[DATA_W];
        w_v   = (r_a[MSB] != w_opb[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      3'd2:    w_res = r_a & w_opb;
      3'd3:    w_res = r_a | w_opb;
      3'd4:    w_res = r_a ^ w_opb;
      3'd5:    w_res = ~r_a;
      3'd6:    w_res = r_a << w_opb[SH_W-1:0];
      default: w_res = r_a >> w_opb[SH_W-1:0];
    endcase
  end

  always_comb begin
    w_wen  = 1'b0;
    w_widx = w_rd;
    if (w_op == c_op_alur) begin
      w_wen = 1'b1;
    end else if (w_op == c_op_alui) begin
      w_wen  = 1'b1;
      w_widx = w_rt;
    end
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_ir      <= '0;
      r_pc      <= '0;
      r_stat    <= '0;
      r_illegal <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_res     <= '0;
      r_flags   <= '0;
      r_target  <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (imem.rdy) r_ir <= imem.data;
        S_DECODE: begin
          r_a   <= rd_reg(w_rs);
          r_b   <= rd_reg(w_rt);
          r_imm <= DATA_W'($signed(r_ir[15:0]));
        end
        S_EXEC: begin
          r_res    <= w_res;
          r_flags  <= {w_c, w_v, w_res[MSB], (w_res == '0)};
          r_target <= r_pc + PC_W'(1) + PC_W'($signed(r_ir[15:0]));
        end
        S_WB: begin
          if (w_wen) begin
            r_stat <= r_flags;
            if (w_widx != 4'd0 && int'(w_widx) < NREGS) r_regs[w_widx] <= r_res;
          end
          case (w_op)
            c_op_nop, c_op_alur, c_op_alui: r_pc <= r_pc + PC_W'(1);
            c_op_brc:  r_pc <= (|(r_stat & w_mm)) ? r_target : r_pc + PC_W'(1);
            c_op_jmp:  r_pc <= PC_W'(r_ir[15:0]);
            c_op_halt: r_pc <= r_pc;
            default: begin
              r_pc      <= r_pc + PC_W'(1);
              r_illegal <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Request is gated by reset so an in-flight fetch drops the moment reset asserts.
  assign imem.req  = (r_state == S_FETCH) && !rst_f;
  assign imem.addr = r_pc;
  assign pc        = r_pc;
  assign stat      = r_stat;
  assign halted    = (r_state == S_HALT);
  assign illegal   = r_illegal;
  assign retire    = (r_state == S_WB);
  assign dbg_data  = rd_reg(dbg_addr);

endmodule

`default_nettype wire

// File: tb/tb_sisc_mc_core.sv
// +----------------------------------------------------------------------+
// | tb_sisc_mc_core : directed self-checking bench for sisc_mc_core       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sisc_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rdy_a, rdy_b;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  logic [15:0] pc_a, pc_b;
  logic [3:0]  stat_a, stat_b, dbg_addr_a, dbg_addr_b;
  logic        halted_a, halted_b, illegal_a, illegal_b, retire_a, retire_b;
  logic [15:0] dbg_data_a;
  logic [31:0] dbg_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  sisc_mc_core_if #(.PC_W(16)) ifa ();
  sisc_mc_core_if #(.PC_W(16)) ifb ();

  assign ifa.rdy  = rdy_a;
  assign ifa.data = mem_a[ifa.addr[3:0]];
  assign ifb.rdy  = rdy_b;
  assign ifb.data = mem_b[ifb.addr[3:0]];

  sisc_mc_core #(.DATA_W(16), .NREGS(16), .PC_W(16)) dut_a (
    .clk(clk), .rst_f(rst_a), .imem(ifa), .pc(pc_a), .stat(stat_a),
    .halted(halted_a), .illegal(illegal_a), .retire(retire_a),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  sisc_mc_core #(.DATA_W(32), .NREGS(4), .PC_W(16)) dut_b (
    .clk(clk), .rst_f(rst_b), .imem(ifb), .pc(pc_b), .stat(stat_b),
    .halted(halted_b), .illegal(illegal_b), .retire(retire_b),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs to the retire pulse, then one more negedge so WB results are visible.
  task automatic run_instr(input bit sel, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? retire_b : retire_a) && cyc < 40);
    check(sel ? "retire_seen_b" : "retire_seen_a", sel ? retire_b : retire_a, 64'd1);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_reg(input bit sel, input string tag, input logic [3:0] idx,
                         input logic [63:0] exp);
    if (sel) dbg_addr_b = idx;
    else     dbg_addr_a = idx;
    #1;
    check(tag, sel ? 64'(dbg_data_b) : 64'(dbg_data_a), exp);
  endtask

  initial begin
    int cyc;
    int n_ret;
    rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b1;
    dbg_addr_a = '0; dbg_addr_b = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'hF000_0000;
      mem_b[i] = 32'hF000_0000;
    end
    mem_a[0] = 32'h2001_7FFF; mem_a[1] = 32'h2002_0001; mem_a[2] = 32'h1012_3000;
    mem_a[3] = 32'h1122_4000; mem_a[4] = 32'h4100_FFFD; mem_a[5] = 32'h2327_00F0;
    mem_a[6] = 32'h3000_0000; mem_a[7] = 32'hF000_0000;
    mem_b[0] = 32'h2001_0001; mem_b[1] = 32'h2002_0021; mem_b[2] = 32'h1612_5000;
    mem_b[3] = 32'h1612_3000; mem_b[4] = 32'h1011_0000; mem_b[5] = 32'h5000_0008;
    mem_b[8] = 32'h2013_FFFF; mem_b[9] = 32'h2513_0000; mem_b[10] = 32'hF000_0000;

    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("fetch_wait_req", ifa.req, 64'd1);
    check("fetch_wait_addr", ifa.addr, 64'd0);
    #2 rst_a = 1'b1;
    #1;
    check("reset_req", ifa.req, 64'd0);
    check("reset_pc", pc_a, 64'd0);
    check("reset_stat", stat_a, 64'd0);
    check("reset_halted", halted_a, 64'd0);
    check("reset_illegal", illegal_a, 64'd0);
    check("reset_retire", retire_a, 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("post_reset_req", ifa.req, 64'd1);
    check("post_reset_addr", ifa.addr, 64'd0);
    rdy_a = 1'b1;

    run_instr(1'b0, cyc); check("lat_i0", cyc, 64'd4);
    chk_reg(1'b0, "r1_7fff", 4'd1, 64'h7FFF);
    check("pc_after_i0", pc_a, 64'd1);
    run_instr(1'b0, cyc); check("lat_i1", cyc, 64'd4);
    chk_reg(1'b0, "r2_one", 4'd2, 64'h0001);
    run_instr(1'b0, cyc); check("lat_i2", cyc, 64'd4);
    chk_reg(1'b0, "r3_ovf", 4'd3, 64'h8000);
    check("stat_ovf", stat_a, 64'b0110);
    run_instr(1'b0, cyc);
    chk_reg(1'b0, "r4_zero", 4'd4, 64'h0000);
    check("stat_sub_zero", stat_a, 64'b1001);
    run_instr(1'b0, cyc);
    check("brc_taken_pc", pc_a, 64'd2);
    check("brc_taken_addr", ifa.addr, 64'd2);
    check("brc_taken_req", ifa.req, 64'd1);
    mem_a[2] = 32'h2006_0002;
    mem_a[3] = 32'h1126_5000;
    mem_a[4] = 32'h4800_FFFD;
    run_instr(1'b0, cyc);
    chk_reg(1'b0, "r6_two", 4'd6, 64'h0002);
    run_instr(1'b0, cyc);
    chk_reg(1'b0, "r5_borrow", 4'd5, 64'hFFFF);
    check("stat_borrow", stat_a, 64'b0010);
    run_instr(1'b0, cyc);
    check("brc_not_taken_pc", pc_a, 64'd5);

    rdy_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_req", ifa.req, 64'd1);
      check("stall_addr", ifa.addr, 64'd5);
    end
    rdy_a = 1'b1;
    run_instr(1'b0, cyc);
    check("lat_stall", cyc + 3, 64'd7);
    chk_reg(1'b0, "r7_or", 4'd7, 64'h00F1);
    check("stat_or", stat_a, 64'b0000);
    run_instr(1'b0, cyc);
    check("illegal_set", illegal_a, 64'd1);
    check("illegal_pc", pc_a, 64'd7);
    run_instr(1'b0, cyc);
    check("halt_halted", halted_a, 64'd1);
    check("halt_req", ifa.req, 64'd0);
    check("halt_pc", pc_a, 64'd7);
    n_ret = 0;
    repeat (20) begin
      @(negedge clk);
      if (retire_a) n_ret++;
    end
    check("halt_no_retire", n_ret, 64'd0);
    check("halt_still", halted_a, 64'd1);
    check("halt_pc_hold", pc_a, 64'd7);
    check("illegal_sticky", illegal_a, 64'd1);

    rst_b = 1'b0;
    run_instr(1'b1, cyc); check("b_lat_i0", cyc, 64'd4);
    chk_reg(1'b1, "b_r1", 4'd1, 64'd1);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_r2", 4'd2, 64'd33);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_r5_absent", 4'd5, 64'd0);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_shl_mod", 4'd3, 64'd2);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_r0_zero", 4'd0, 64'd0);
    check("b_stat_add", stat_b, 64'b0000);
    run_instr(1'b1, cyc);
    check("b_jmp_pc", pc_b, 64'd8);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_add_neg", 4'd3, 64'd0);
    check("b_stat_carry_zero", stat_b, 64'b1001);
    run_instr(1'b1, cyc);
    chk_reg(1'b1, "b_not", 4'd3, 64'hFFFF_FFFE);
    check("b_stat_not", stat_b, 64'b0010);
    run_instr(1'b1, cyc);
    check("b_halted", halted_b, 64'd1);
    check("b_halt_pc", pc_b, 64'd10);
    check("b_halt_req", ifb.req, 64'd0);
    check("b_no_illegal", illegal_b, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
